counter_monitor: RTL and testbench
==================================

Name: counter_monitor

Overview:
- Downstream checker for the 5-state coded counter. Samples the 5-bit code and the same `mode` line that drives the counter, once per clock.
- Decodes each code to an index 0..4 and checks that every step obeys the up/down sequence.
- Counts laps (wraps) and errors, and holds `valid` low until it has re-locked after an illegal code.
- Feeds the board LED/seven-segment display and the debug status logic.

Parameters:
- CNT_W, 8, width of lap_count and err_count (saturating).
- RESYNC_N, 2, consecutive correct steps required in FAULT before valid reasserts (1..7).

Ports:
- clk  input  1  rising-edge clock, same clock as the counter.
- rst  input  1  asynchronous active-low reset.
- code  input  5  counter output.
- mode  input  1  direction into the counter: 0 = up, 1 = down.
- clear  input  1  synchronous clear of err_sticky, err_count and lap_count.
- index  output  3  decoded position 0..4 of the last legal code.
- valid  output  1  1 = monitor is locked and index is trustworthy.
- step_err  output  1  one-cycle pulse marking an illegal code or a wrong transition.
- err_sticky  output  1  set by any step_err; cleared only by rst or clear.
- lap_count  output  CNT_W  wraps seen while locked, saturating.
- err_count  output  CNT_W  error events, saturating.

Behaviour:
- Code map:
  - 00001 = 0, 01000 = 1, 00011 = 2, 10101 = 3, 10000 = 4.
  - Every other code is illegal.
- Expected next index:
  - mode = 0: (i + 1) mod 5.
  - mode = 1: (i + 4) mod 5.
  - Uses prev_mode, the mode registered on the same edge as the previous code.
- Reset (rst = 0, asynchronous):
  - FSM = SYNC.
  - index = 0, valid = 0, step_err = 0, err_sticky = 0, lap_count = 0, err_count = 0.
  - prev_idx = 0, prev_mode = 0, good_cnt = 0.
- All outputs are registered. Each output reflects the sample taken at the preceding rising edge, giving 1 cycle latency.
- FSM SYNC (first sample after reset):
  - legal code: load prev_idx and prev_mode, index = decoded value, valid = 1, go to TRACK. No transition check.
  - illegal code: step_err = 1, err_count +1, stay in SYNC.
- FSM TRACK:
  - legal and equal to expected: update index, prev_idx and prev_mode.
    - Wrap 4 -> 0 with mode = 0: lap_count +1.
    - Wrap 0 -> 4 with mode = 1: lap_count +1.
  - legal but not expected (skip, stall, or wrong direction):
    - step_err = 1, err_count +1.
    - Resync to the observed code: index = observed, prev_idx = observed.
    - Stay in TRACK; valid stays 1.
  - illegal code: step_err = 1, err_count +1, valid = 0, good_cnt = 0, go to FAULT. index holds its last value.
- FSM FAULT:
  - first legal code: load prev_idx and prev_mode, good_cnt = 0.
  - each following correct step: good_cnt +1. When good_cnt reaches RESYNC_N, set valid = 1 and go to TRACK.
  - illegal code or wrong step: step_err = 1, err_count +1, good_cnt = 0. A legal code reloads prev_idx.
  - lap_count does not count while in FAULT.
- err_sticky is set on the same edge as any step_err.
- Counters saturate at 2^CNT_W - 1 and never wrap.
- clear:
  - Zeroes err_sticky, err_count and lap_count.
  - Wins over an error or lap event on the same edge: that event is not counted, but step_err still pulses.
  - FSM, index and valid are unaffected.
- mode toggling is legal at any edge. The check always uses the mode that was registered with the previous code.
- rst asserted mid-operation returns every output to its reset value immediately. No state survives.

Test Plan:
- Reset, then mode = 0, counter free-running for 12 cycles:
  - valid = 1 one cycle after the first sample.
  - index runs 0,1,2,3,4,0,1,2,3,4,…
  - lap_count = 2 after the second 4 -> 0 wrap; step_err never asserts.
- Hold mode = 1 from reset:
  - index runs 0,4,3,2,1,0; lap_count = 1 on 0 -> 4.
  - Toggle mode mid-run at index 2: next index = 3 (or 1), no error.
- Force code = 00011 directly after 00001 (skip) while mode = 0:
  - step_err pulses 1 cycle, err_count = 1, err_sticky = 1.
  - index = 2, valid stays 1.
- Force code = 11111 for 3 cycles, then a legal sequence with RESYNC_N = 2:
  - valid = 0 from the first bad sample; err_count = 3.
  - valid returns to 1 after the 1st legal code plus 2 correct steps; no laps counted while in FAULT.
- Pulse clear on the same edge as a wrong transition:
  - step_err = 1, but err_count = 0, lap_count = 0, err_sticky = 0.
- Set CNT_W = 2 and inject 5 errors:
  - err_count saturates at 3.
  - Then assert rst mid-run: all outputs return to reset values immediately, asynchronously.

Source files
------------

// File: rtl/counter_monitor.sv
// counter_monitor: checks the 5-state coded counter sampled once per clock.
// It decodes each code to an index 0..4, confirms each step follows the
// direction given by mode, counts laps and errors, and drops valid after an
// illegal code until it has seen enough correct steps to lock again.
//
// Ports:
//   clk        rising-edge clock, shared with the counter
//   rst        asynchronous active-low reset
//   code       5-bit counter output
//   mode       counter direction: 0 = up, 1 = down
//   clear      synchronous clear of err_sticky, err_count and lap_count
//   index      decoded position of the last legal code
//   valid      monitor is locked and index is trustworthy
//   step_err   one-cycle pulse for an illegal code or a wrong transition
//   err_sticky latched error flag, cleared by rst or clear
//   lap_count  wraps seen while locked (saturating)
//   err_count  error events (saturating)
module counter_monitor #(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned RESYNC_N = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       code,
    input  logic             mode,
    input  logic             clear,
    output logic [2:0]       index,
    output logic             valid,
    output logic             step_err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] lap_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int unsigned IDX_W  = 3;
    localparam int unsigned GOOD_W = 3;
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(RESYNC_N - 1);

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  prev_idx;
    logic              prev_mode;
    logic [GOOD_W-1:0] good_cnt;
    logic              have_prev;

    logic              legal_c;
    logic [IDX_W-1:0]  dec_idx_c;
    logic [IDX_W-1:0]  exp_idx_c;
    logic              step_ok_c;
    logic              wrap_c;
    logic              err_ev_c;
    logic              lap_ev_c;

    // Code map decode
    always_comb begin
        legal_c   = 1'b1;
        dec_idx_c = 3'd0;
        unique case (code)
            5'b00001: dec_idx_c = 3'd0;
            5'b01000: dec_idx_c = 3'd1;
            5'b00011: dec_idx_c = 3'd2;
            5'b10101: dec_idx_c = 3'd3;
            5'b10000: dec_idx_c = 3'd4;
            default:  legal_c   = 1'b0;
        endcase
    end

    // Expected successor of prev_idx in the direction registered with it
    always_comb begin
        if (prev_mode) begin
            exp_idx_c = (prev_idx == 3'd0) ? 3'd4 : IDX_W'(prev_idx - 3'd1);
        end else begin
            exp_idx_c = (prev_idx == 3'd4) ? 3'd0 : IDX_W'(prev_idx + 3'd1);
        end
    end

    assign step_ok_c = legal_c && (dec_idx_c == exp_idx_c);
    // A correct step across the 4/0 boundary is a lap in either direction
    assign wrap_c    = ((prev_idx == 3'd4) && (dec_idx_c == 3'd0)) ||
                       ((prev_idx == 3'd0) && (dec_idx_c == 3'd4));

    // Error and lap events for the current sample
    always_comb begin
        err_ev_c = 1'b0;
        lap_ev_c = 1'b0;
        unique case (state)
            SYNC:    err_ev_c = !legal_c;
            TRACK: begin
                err_ev_c = !step_ok_c;
                lap_ev_c = step_ok_c && wrap_c;
            end
            FAULT:   err_ev_c = !legal_c || (have_prev && !step_ok_c);
            default: err_ev_c = 1'b0;
        endcase
    end

    // Monitor state, tracking registers and outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= SYNC;
            prev_idx   <= '0;
            prev_mode  <= 1'b0;
            good_cnt   <= '0;
            have_prev  <= 1'b0;
            index      <= '0;
            valid      <= 1'b0;
            step_err   <= 1'b0;
            err_sticky <= 1'b0;
            lap_count  <= '0;
            err_count  <= '0;
        end else begin
            step_err <= err_ev_c;

            // clear beats any event on the same edge
            if (clear) begin
                err_sticky <= 1'b0;
                err_count  <= '0;
                lap_count  <= '0;
            end else begin
                if (err_ev_c) begin
                    err_sticky <= 1'b1;
                    if (err_count != CNT_MAX) err_count <= err_count + 1'b1;
                end
                if (lap_ev_c && (lap_count != CNT_MAX)) lap_count <= lap_count + 1'b1;
            end

            // Every legal code becomes the reference for the next step
            if (legal_c) begin
                prev_idx  <= dec_idx_c;
                prev_mode <= mode;
                index     <= dec_idx_c;
            end

            unique case (state)
                SYNC: begin
                    if (legal_c) begin
                        valid <= 1'b1;
                        state <= TRACK;
                    end
                end
                TRACK: begin
                    if (!legal_c) begin
                        valid     <= 1'b0;
                        good_cnt  <= '0;
                        have_prev <= 1'b0;
                        state     <= FAULT;
                    end
                end
                FAULT: begin
                    if (!legal_c) begin
                        good_cnt  <= '0;
                        have_prev <= 1'b0;
                    end else if (!have_prev) begin
                        have_prev <= 1'b1;
                        good_cnt  <= '0;
                    end else if (step_ok_c) begin
                        if (good_cnt == GOOD_LAST) begin
                            good_cnt <= '0;
                            valid    <= 1'b1;
                            state    <= TRACK;
                        end else begin
                            good_cnt <= good_cnt + 1'b1;
                        end
                    end else begin
                        good_cnt <= '0;
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_monitor.sv
// tb_counter_monitor: directed and randomized checks of counter_monitor
// against a behavioural reference model of the lock / lap / error rules.
module tb_counter_monitor;

    localparam int unsigned CNT_W    = 8;
    localparam int unsigned RESYNC_N = 2;
    localparam int          CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic [4:0]       code;
    logic             mode;
    logic             clear;
    logic [2:0]       index;
    logic             valid;
    logic             step_err;
    logic             err_sticky;
    logic [CNT_W-1:0] lap_count;
    logic [CNT_W-1:0] err_count;

    counter_monitor #(.CNT_W(CNT_W), .RESYNC_N(RESYNC_N)) dut (
        .clk       (clk),
        .rst       (rst),
        .code      (code),
        .mode      (mode),
        .clear     (clear),
        .index     (index),
        .valid     (valid),
        .step_err  (step_err),
        .err_sticky(err_sticky),
        .lap_count (lap_count),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [4:0] code_tbl [5] = '{5'b00001, 5'b01000, 5'b00011, 5'b10101, 5'b10000};

    // Reference model state
    bit m_seen;       // a legal code has been seen since reset
    bit m_locked;     // monitor considers itself locked
    bit m_have_prev;  // while unlocked: a legal reference code exists
    int m_run;        // consecutive correct steps while unlocked
    int m_prev;
    bit m_pmode;
    int m_index;
    bit m_step_err;
    bit m_sticky;
    int m_laps;
    int m_errs;

    int ctr;  // position of the free-running counter being emulated

    function automatic logic [4:0] code_of(input int i);
        return code_tbl[i];
    endfunction

    function automatic int decode_ref(input logic [4:0] c);
        for (int i = 0; i < 5; i++) if (code_tbl[i] == c) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_seen = 0; m_locked = 0; m_have_prev = 0; m_run = 0;
        m_prev = 0; m_pmode = 0; m_index = 0;
        m_step_err = 0; m_sticky = 0; m_laps = 0; m_errs = 0;
    endtask

    task automatic model_step(input logic [4:0] c, input logic m, input logic clr);
        int  d;
        int  want;
        bit  err;
        bit  lap;
        d    = decode_ref(c);
        err  = 0;
        lap  = 0;
        want = m_pmode ? (m_prev + 4) % 5 : (m_prev + 1) % 5;
        if (!m_seen) begin
            if (d < 0) err = 1;
            else m_seen = 1;
            if (d >= 0) m_locked = 1;
        end else if (m_locked) begin
            if (d < 0) begin
                err = 1; m_locked = 0; m_have_prev = 0; m_run = 0;
            end else if (d != want) begin
                err = 1;
            end else begin
                lap = (m_prev == 4 && d == 0) || (m_prev == 0 && d == 4);
            end
        end else begin
            if (d < 0) begin
                err = 1; m_have_prev = 0; m_run = 0;
            end else if (!m_have_prev) begin
                m_have_prev = 1; m_run = 0;
            end else if (d == want) begin
                m_run++;
                if (m_run == RESYNC_N) m_locked = 1;
            end else begin
                err = 1; m_run = 0;
            end
        end
        if (d >= 0) begin
            m_prev = d; m_pmode = m; m_index = d;
        end
        m_step_err = err;
        if (clr) begin
            m_sticky = 0; m_errs = 0; m_laps = 0;
        end else begin
            if (err) begin
                m_sticky = 1;
                if (m_errs < CNT_MAX) m_errs++;
            end
            if (lap && m_laps < CNT_MAX) m_laps++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".index"},      32'(index),      32'(m_index));
        chk({tag, ".valid"},      32'(valid),      32'(m_locked));
        chk({tag, ".step_err"},   32'(step_err),   32'(m_step_err));
        chk({tag, ".err_sticky"}, 32'(err_sticky), 32'(m_sticky));
        chk({tag, ".lap_count"},  32'(lap_count),  32'(m_laps));
        chk({tag, ".err_count"},  32'(err_count),  32'(m_errs));
    endtask

    // Apply one sample, let the model see the same edge, compare after it
    task automatic tick(input logic [4:0] c, input logic m, input logic clr, input string tag);
        code  = c;
        mode  = m;
        clear = clr;
        @(posedge clk);
        model_step(c, m, clr);
        #1;
        check_all(tag);
    endtask

    task automatic run_cnt(input int n, input logic m, input string tag);
        for (int i = 0; i < n; i++) begin
            tick(code_of(ctr), m, 1'b0, tag);
            ctr = m ? (ctr + 4) % 5 : (ctr + 1) % 5;
        end
    endtask

    // Assert reset between edges and check it takes effect without a clock
    task automatic do_reset(input string tag);
        #1;
        rst = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst = 1'b1;
        ctr = 0;
    endtask

    initial begin
        logic [4:0] rc;
        logic       rmode;
        logic       rclr;
        int         r;

        rst = 1'b0; code = 5'b00001; mode = 1'b0; clear = 1'b0; ctr = 0;
        #3;
        model_reset();
        check_all("por");
        @(negedge clk);
        rst = 1'b1;

        // Free-running up count
        run_cnt(1, 1'b0, "up_first");
        chk("up_first_valid", 32'(valid), 32'd1);
        chk("up_first_index", 32'(index), 32'd0);
        run_cnt(11, 1'b0, "up_run");
        chk("up_laps", 32'(lap_count), 32'd2);
        chk("up_index", 32'(index), 32'd1);
        chk("up_sticky", 32'(err_sticky), 32'd0);

        // Down count from reset, then reverse direction at index 2
        do_reset("rst_down");
        run_cnt(6, 1'b1, "down_run");
        chk("down_laps", 32'(lap_count), 32'd1);
        chk("down_index", 32'(index), 32'd0);
        do_reset("rst_toggle");
        run_cnt(3, 1'b1, "toggle_down");
        run_cnt(2, 1'b0, "toggle_up");
        chk("toggle_index", 32'(index), 32'd3);
        chk("toggle_errs", 32'(err_count), 32'd0);

        // Skip from 0 to 2 while counting up
        do_reset("rst_skip");
        tick(code_of(0), 1'b0, 1'b0, "skip_a");
        tick(code_of(2), 1'b0, 1'b0, "skip_b");
        chk("skip_step_err", 32'(step_err), 32'd1);
        chk("skip_errs", 32'(err_count), 32'd1);
        chk("skip_index", 32'(index), 32'd2);
        chk("skip_valid", 32'(valid), 32'd1);
        tick(code_of(3), 1'b0, 1'b0, "skip_c");
        chk("skip_pulse_end", 32'(step_err), 32'd0);
        chk("skip_sticky", 32'(err_sticky), 32'd1);

        // Illegal burst then relock across a wrap
        do_reset("rst_fault");
        tick(code_of(0), 1'b0, 1'b0, "fault_lock");
        tick(5'b11111, 1'b0, 1'b0, "fault_bad1");
        chk("fault_valid_drop", 32'(valid), 32'd0);
        chk("fault_index_hold", 32'(index), 32'd0);
        tick(5'b11111, 1'b0, 1'b0, "fault_bad2");
        tick(5'b11111, 1'b0, 1'b0, "fault_bad3");
        chk("fault_errs", 32'(err_count), 32'd3);
        ctr = 3;
        run_cnt(2, 1'b0, "fault_relock");
        chk("fault_still_low", 32'(valid), 32'd0);
        run_cnt(1, 1'b0, "fault_relock_wrap");
        chk("fault_relocked", 32'(valid), 32'd1);
        chk("fault_no_lap", 32'(lap_count), 32'd0);
        run_cnt(1, 1'b0, "fault_track");

        // clear racing a lap and then an error
        do_reset("rst_clear");
        run_cnt(5, 1'b0, "clear_pre");
        tick(code_of(0), 1'b0, 1'b1, "clear_lap");
        chk("clear_lap_count", 32'(lap_count), 32'd0);
        tick(code_of(2), 1'b0, 1'b1, "clear_err");
        chk("clear_step_err", 32'(step_err), 32'd1);
        chk("clear_err_count", 32'(err_count), 32'd0);
        chk("clear_sticky", 32'(err_sticky), 32'd0);
        ctr = 3;

        // Randomized traffic: direction changes, skips, illegal codes, clears
        do_reset("rst_rand");
        rmode = 1'b0;
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 99));
            if ($urandom_range(0, 9) == 0) rmode = ~rmode;
            rclr = ($urandom_range(0, 29) == 0);
            if (r < 6) begin
                rc = 5'($urandom_range(0, 31));
                if (decode_ref(rc) >= 0) rc = 5'b11111;
                tick(rc, rmode, rclr, "rand_bad");
            end else begin
                if (r < 12) ctr = int'($urandom_range(0, 4));
                tick(code_of(ctr), rmode, rclr, "rand");
                ctr = rmode ? (ctr + 4) % 5 : (ctr + 1) % 5;
            end
        end

        // Error counter saturation, then reset mid-run
        do_reset("rst_sat");
        for (int i = 0; i < 260; i++) tick(5'b11111, 1'b0, 1'b0, "sat");
        chk("sat_errs", 32'(err_count), 32'(CNT_MAX));
        chk("sat_valid", 32'(valid), 32'd0);
        run_cnt(3, 1'b0, "sat_lock");
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("async_index", 32'(index), 32'd0);
        chk("async_valid", 32'(valid), 32'd0);
        chk("async_errs", 32'(err_count), 32'd0);
        chk("async_sticky", 32'(err_sticky), 32'd0);
        check_all("async");
        @(negedge clk);
        rst = 1'b1;
        ctr = 0;
        run_cnt(2, 1'b0, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
